// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared constants for the GMII transmit arbiter: data width,
//               default timing parameters and the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    // GMII data path width in bits
    localparam int c_GMII_W = 8;

    // Default timing parameters (all in gmii_tx_clk cycles)
    localparam int c_IFG_CYCLES = 12;
    localparam int c_START_TMO  = 64;
    localparam int c_MAX_LEN    = 1530;

    // Arbiter state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_SEND  = 2'd2;
    localparam logic [1:0] c_ST_IFG   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gmii_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : gmii_rr_pick
// Description : Combinational two-way round-robin winner select.
//               The source that was not served last wins if it requests,
//               otherwise the last-served source wins if it requests.
// Ports       : i_req     - per-source request
//               i_last_id - index of the last granted source
//               o_valid   - at least one source is requesting
//               o_winner  - index of the selected source
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_id,
    output logic       o_valid,
    output logic       o_winner
);

    logic w_other;

    assign w_other = ~i_last_id;

    always_comb begin
        o_valid  = |i_req;
        o_winner = i_req[w_other] ? w_other : i_last_id;
    end

endmodule
`default_nettype wire

// File: rtl/gmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_arbiter
// Description : Shares one GMII transmit path between two packet sources.
//               Whole packets are granted round-robin, an inter-frame gap is
//               forced after every packet, a granted source that never starts
//               is timed out and an over-long packet is truncated.
// Ports       : gmii_tx_clk - sole clock (125 MHz)
//               rst         - synchronous active-high reset
//               src_req     - per-source request, held until packet sent
//               src_gnt     - per-source grant, one-hot or zero
//               src_tx_en   - per-source GMII enable
//               src_txd     - per-source GMII data, [7:0] src0, [15:8] src1
//               gmii_tx_en  - arbitrated GMII enable
//               gmii_txd    - arbitrated GMII data, 0 when not enabled
//               busy        - arbiter is not idle
//               act_id      - index of the last or current granted source
//               tmo_pulse   - grant revoked because the source never started
//               abort_pulse - packet truncated at MAX_LEN
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_arbiter
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES = c_IFG_CYCLES,
    parameter int START_TMO  = c_START_TMO,
    parameter int MAX_LEN    = c_MAX_LEN
) (
    input  logic                  gmii_tx_clk,
    input  logic                  rst,
    input  logic [1:0]            src_req,
    output logic [1:0]            src_gnt,
    input  logic [1:0]            src_tx_en,
    input  logic [2*c_GMII_W-1:0] src_txd,
    output logic                  gmii_tx_en,
    output logic [c_GMII_W-1:0]   gmii_txd,
    output logic                  busy,
    output logic                  act_id,
    output logic                  tmo_pulse,
    output logic                  abort_pulse
);

    localparam logic [15:0] c_LEN_MAX  = 16'(MAX_LEN);
    localparam logic [15:0] c_TMO_LAST = 16'(START_TMO - 1);
    localparam logic [7:0]  c_IFG_LAST = 8'(IFG_CYCLES - 1);

    logic [1:0]          r_state;
    logic [1:0]          r_gnt;
    logic                r_act_id;
    logic                r_tx_en;
    logic [c_GMII_W-1:0] r_txd;
    logic                r_tmo_pulse;
    logic                r_abort_pulse;
    logic [15:0]         r_wait;
    logic [15:0]         r_len;
    logic [7:0]          r_ifg;
    // A truncated source keeps its request parked here until it lets go,
    // so its leftover bytes can never be granted as a fresh packet.
    logic [1:0]          r_blk;

    logic [1:0]          w_req;
    logic                w_win_valid;
    logic                w_winner;
    logic                w_sel_en;
    logic [c_GMII_W-1:0] w_sel_txd;

    assign w_req     = src_req & ~r_blk;
    assign w_sel_en  = src_tx_en[r_act_id];
    assign w_sel_txd = r_act_id ? src_txd[2*c_GMII_W-1:c_GMII_W] : src_txd[c_GMII_W-1:0];

    gmii_rr_pick u_rr_pick (
        .i_req     (w_req),
        .i_last_id (r_act_id),
        .o_valid   (w_win_valid),
        .o_winner  (w_winner)
    );

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_gnt         <= 2'b00;
            r_act_id      <= 1'b1;
            r_tx_en       <= 1'b0;
            r_txd         <= '0;
            r_tmo_pulse   <= 1'b0;
            r_abort_pulse <= 1'b0;
            r_wait        <= 16'd0;
            r_len         <= 16'd0;
            r_ifg         <= 8'd0;
            r_blk         <= 2'b00;
        end else begin
            r_tmo_pulse   <= 1'b0;
            r_abort_pulse <= 1'b0;
            r_blk         <= r_blk & src_req;

            case (r_state)
                c_ST_IDLE: begin
                    r_tx_en <= 1'b0;
                    r_txd   <= '0;
                    if (w_win_valid) begin
                        r_gnt    <= w_winner ? 2'b10 : 2'b01;
                        r_act_id <= w_winner;
                        r_wait   <= 16'd0;
                        r_state  <= c_ST_GRANT;
                    end
                end

                c_ST_GRANT: begin
                    if (w_sel_en) begin
                        // First byte is forwarded in the same cycle it is seen
                        r_tx_en <= 1'b1;
                        r_txd   <= w_sel_txd;
                        r_len   <= 16'd1;
                        r_state <= c_ST_SEND;
                    end else if (!src_req[r_act_id]) begin
                        r_gnt   <= 2'b00;
                        r_state <= c_ST_IDLE;
                    end else if (r_wait == c_TMO_LAST) begin
                        // Nothing was sent, so no gap is needed
                        r_gnt       <= 2'b00;
                        r_tmo_pulse <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end

                c_ST_SEND: begin
                    if (!w_sel_en) begin
                        r_tx_en <= 1'b0;
                        r_txd   <= '0;
                        r_gnt   <= 2'b00;
                        r_ifg   <= 8'd0;
                        r_state <= c_ST_IFG;
                    end else if (r_len == c_LEN_MAX) begin
                        r_tx_en         <= 1'b0;
                        r_txd           <= '0;
                        r_gnt           <= 2'b00;
                        r_abort_pulse   <= 1'b1;
                        r_blk[r_act_id] <= 1'b1;
                        r_ifg           <= 8'd0;
                        r_state         <= c_ST_IFG;
                    end else begin
                        r_tx_en <= 1'b1;
                        r_txd   <= w_sel_txd;
                        r_len   <= r_len + 16'd1;
                    end
                end

                c_ST_IFG: begin
                    r_tx_en <= 1'b0;
                    r_txd   <= '0;
                    if (r_ifg == c_IFG_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_ifg <= r_ifg + 8'd1;
                    end
                end

                default: begin
                    r_tx_en <= 1'b0;
                    r_txd   <= '0;
                    r_gnt   <= 2'b00;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign src_gnt     = r_gnt;
    assign gmii_tx_en  = r_tx_en;
    assign gmii_txd    = r_txd;
    assign busy        = (r_state != c_ST_IDLE);
    assign act_id      = r_act_id;
    assign tmo_pulse   = r_tmo_pulse;
    assign abort_pulse = r_abort_pulse;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmii_tx_arbiter
// Description : Directed self-checking bench for gmii_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_arbiter;

    logic        gmii_tx_clk = 1'b0;
    logic        rst;
    logic [1:0]  src_req;
    logic [1:0]  src_gnt;
    logic [1:0]  src_tx_en;
    logic [15:0] src_txd;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        busy;
    logic        act_id;
    logic        tmo_pulse;
    logic        abort_pulse;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // packet-stream bookkeeping for the two-source phase
    int          idx [2];
    int          sent [2];
    bit          act [2];
    int          order [4];
    int          npk;
    int          gap;
    bit          seen;
    logic        prev_en;
    logic        exp_en;
    logic [7:0]  exp_txd;
    int          g0;

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    gmii_tx_arbiter dut (
        .gmii_tx_clk (gmii_tx_clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_gnt     (src_gnt),
        .src_tx_en   (src_tx_en),
        .src_txd     (src_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .busy        (busy),
        .act_id      (act_id),
        .tmo_pulse   (tmo_pulse),
        .abort_pulse (abort_pulse)
    );

    function automatic logic [7:0] byte0(input int i);
        return 8'(i * 7 + 3) & 8'h7F;
    endfunction

    function automatic logic [7:0] byte1(input int i);
        return 8'(i * 5) | 8'h80;
    endfunction

    task automatic tick();
        @(negedge gmii_tx_clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic drive(input int s, input int i);
        src_tx_en[s] = 1'b1;
        if (s == 0) src_txd[7:0]  = byte0(i);
        else        src_txd[15:8] = byte1(i);
    endtask

    task automatic quiet(input int s);
        src_tx_en[s] = 1'b0;
        if (s == 0) src_txd[7:0]  = 8'hEE;
        else        src_txd[15:8] = 8'hEE;
    endtask

    initial begin
        rst       = 1'b1;
        src_req   = 2'b00;
        src_tx_en = 2'b00;
        src_txd   = 16'h0000;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_gnt", src_gnt, 2'b00);
        check("rst_en", gmii_tx_en, 1'b0);
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_act", act_id, 1'b1);
        check("rst_tmo", tmo_pulse, 1'b0);
        check("rst_abort", abort_pulse, 1'b0);
        rst = 1'b0;

        // ---------------- single source, 72-byte packet ----------------
        src_req = 2'b01;
        tick();
        check("t1_gnt", src_gnt, 2'b01);
        check("t1_act", act_id, 1'b0);
        check("t1_busy", busy, 1'b1);
        drive(0, 0);
        for (int i = 1; i <= 72; i++) begin
            tick();
            check("t1_en", gmii_tx_en, 1'b1);
            check("t1_txd", gmii_txd, byte0(i - 1));
            if (i < 72) begin
                drive(0, i);
            end else begin
                quiet(0);
                src_req[0] = 1'b0;
            end
        end
        tick();
        check("t1_end_en", gmii_tx_en, 1'b0);
        check("t1_end_gnt", src_gnt, 2'b00);
        check("t1_end_busy", busy, 1'b1);
        for (int i = 1; i < 12; i++) begin
            tick();
            check("t1_ifg_busy", busy, 1'b1);
            check("t1_ifg_en", gmii_tx_en, 1'b0);
        end
        tick();
        check("t1_idle", busy, 1'b0);

        // ---------------- both sources, 64-byte packets ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_req = 2'b11;
        npk = 0; gap = 0; seen = 0; prev_en = 1'b0;
        exp_en = 1'b0; exp_txd = 8'h00;
        for (int s = 0; s < 2; s++) begin
            act[s] = 0; idx[s] = 0; sent[s] = 0;
            quiet(s);
        end
        for (int c = 0; c < 800; c++) begin
            tick();
            check("t2_en", gmii_tx_en, exp_en);
            check("t2_txd", gmii_txd, exp_txd);
            if (gmii_tx_en) begin
                if (!prev_en && seen) check("t2_gap", (gap >= 13), 1'b1);
                gap  = 0;
                seen = 1;
            end else begin
                gap++;
            end
            prev_en = gmii_tx_en;
            for (int s = 0; s < 2; s++) begin
                if (act[s]) begin
                    if (idx[s] < 64) begin
                        drive(s, idx[s]);
                        idx[s]++;
                    end else begin
                        quiet(s);
                        act[s] = 0;
                        sent[s]++;
                        if (sent[s] >= 2) src_req[s] = 1'b0;
                    end
                end else if (src_gnt[s] && src_req[s] && npk < 4) begin
                    act[s] = 1;
                    drive(s, 0);
                    idx[s] = 1;
                    order[npk] = s;
                    npk++;
                end
            end
            exp_en  = |src_tx_en;
            exp_txd = src_tx_en[0] ? src_txd[7:0] : (src_tx_en[1] ? src_txd[15:8] : 8'h00);
            if (npk == 4 && !act[0] && !act[1] && busy == 1'b0) break;
        end
        check("t2_pkts", npk, 4);
        check("t2_idle", busy, 1'b0);
        for (int k = 0; k < 4; k++) check("t2_order", order[k], k % 2);

        // ---------------- start timeout, then drop req in GRANT ----------------
        src_txd = 16'h0000;
        src_req = 2'b10;
        tick();
        check("t3_gnt", src_gnt, 2'b10);
        src_req = 2'b11;
        for (int k = 1; k < 64; k++) begin
            tick();
            check("t3_wait_tmo", tmo_pulse, 1'b0);
            check("t3_wait_gnt", src_gnt, 2'b10);
        end
        tick();
        check("t3_tmo", tmo_pulse, 1'b1);
        check("t3_tmo_gnt", src_gnt, 2'b00);
        check("t3_tmo_busy", busy, 1'b0);
        tick();
        check("t3_tmo_once", tmo_pulse, 1'b0);
        check("t3_next_gnt", src_gnt, 2'b01);
        check("t3_next_act", act_id, 1'b0);
        src_req = 2'b00;
        tick();
        check("t5_drop_gnt", src_gnt, 2'b00);
        check("t5_drop_busy", busy, 1'b0);
        check("t5_drop_tmo", tmo_pulse, 1'b0);
        check("t5_drop_abort", abort_pulse, 1'b0);

        // ---------------- truncation at 1530 bytes ----------------
        src_req = 2'b01;
        tick();
        check("t4_gnt", src_gnt, 2'b01);
        g0 = cyc;
        drive(0, 0);
        src_req[1] = 1'b1;
        for (int i = 1; i <= 1530; i++) begin
            tick();
            check("t4_en", gmii_tx_en, 1'b1);
            check("t4_txd", gmii_txd, byte0(i - 1));
            drive(0, i);
        end
        tick();
        check("t4_cut_en", gmii_tx_en, 1'b0);
        check("t4_abort", abort_pulse, 1'b1);
        check("t4_cut_gnt", src_gnt, 2'b00);
        drive(0, 1531);
        for (int i = 1; i < 12; i++) begin
            tick();
            check("t4_ifg_en", gmii_tx_en, 1'b0);
            check("t4_ifg_busy", busy, 1'b1);
            drive(0, 1531 + i);
        end
        tick();
        check("t4_idle", busy, 1'b0);
        check("t4_abort_once", abort_pulse, 1'b0);
        tick();
        check("t4_gnt1", src_gnt, 2'b10);
        check("t4_act1", act_id, 1'b1);
        drive(1, 0);
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("t4_s1_en", gmii_tx_en, 1'b1);
            check("t4_s1_txd", gmii_txd, byte1(j - 1));
            if (j < 8) begin
                drive(1, j);
            end else begin
                quiet(1);
                src_req[1] = 1'b0;
            end
        end
        tick();
        check("t4_s1_end", gmii_tx_en, 1'b0);
        while (cyc - g0 < 2000) begin
            tick();
            check("t4_blk_gnt", src_gnt, 2'b00);
            check("t4_blk_en", gmii_tx_en, 1'b0);
        end
        quiet(0);
        src_req[0] = 1'b0;
        tick();
        src_req[0] = 1'b1;
        tick();
        check("t4_regrant", src_gnt, 2'b01);
        src_req = 2'b00;
        tick();
        check("t4_regrant_drop", src_gnt, 2'b00);

        // ---------------- reset mid-packet ----------------
        src_req = 2'b01;
        tick();
        check("t6_gnt", src_gnt, 2'b01);
        drive(0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t6_en", gmii_tx_en, 1'b1);
            check("t6_txd", gmii_txd, byte0(i - 1));
            drive(0, i);
        end
        rst = 1'b1;
        tick();
        check("t6_rst_en", gmii_tx_en, 1'b0);
        check("t6_rst_txd", gmii_txd, 8'h00);
        check("t6_rst_gnt", src_gnt, 2'b00);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_act", act_id, 1'b1);
        rst = 1'b0;
        quiet(0);
        src_req = 2'b11;
        tick();
        check("t6_after_gnt", src_gnt, 2'b01);
        check("t6_after_act", act_id, 1'b0);
        src_req = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
